// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC register, req/ack instruction memory port, held instruction for decode.
// Defining FETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        instr_valid
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned JIDX_W = 26;
    localparam int unsigned SEG_W  = XLEN - JIDX_W - 2;

    localparam logic [XLEN-1:0] PC_RST    = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] br_off_c;
    logic [XLEN-1:0] next_pc_c;
    logic            ack_accept_c;
    logic            stall_hold_c;

    assign imem_addr    = fetch_pc;
    assign ack_accept_c = (state == ST_FETCH) && imem_ack;
    assign stall_hold_c = (state == ST_VALID) && stall;

    // Next-PC select from the held instruction; jump outranks branch.
    always_comb begin
        br_off_c  = {{(XLEN - OFF_W - 2){instr[OFF_W-1]}}, instr[OFF_W-1:0], 2'b00};
        next_pc_c = pc_plus4;
        if (jump) begin
            next_pc_c = {pc_plus4[XLEN-1 -: SEG_W], instr[JIDX_W-1:0], 2'b00};
        end else if (branch_taken) begin
            next_pc_c = pc_plus4 + br_off_c;
        end
    end

    // Fetch FSM with registered outputs; the next PC only reaches imem_addr through fetch_pc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= PC_RST;
            pc          <= '0;
            pc_plus4    <= WORD_STEP;
            instr       <= '0;
            opcode      <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        opcode      <= imem_rdata[XLEN-1 -: OP_W];
                        pc          <= fetch_pc;
                        pc_plus4    <= fetch_pc + WORD_STEP;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        fetch_pc    <= next_pc_c;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (ack_accept_c) fetch_count <= fetch_count + XLEN'(1);
            if (stall_hold_c) stall_count <= stall_count + XLEN'(1);
        end
    end
`else
    logic unused_perf_c;
    assign unused_perf_c = ack_accept_c ^ stall_hold_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequence, then randomized fetch/stall/redirect traffic.
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count  (fetch_count),
        .stall_count  (stall_count),
`endif
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: next expected fetch address and the instruction currently held.
    logic [31:0] exp_addr;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    int          exp_fetches;
    int          exp_stalls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS next-PC rule in plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input bit j, input bit b);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b) begin
            off = int'($signed(w[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic do_fetch(input logic [31:0] word, input int delay);
        int guard;
        guard = 0;
        while (!imem_req && guard < 8) begin
            tick();
            guard++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        for (int d = 0; d < delay; d++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            tick();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_instr", instr, held_instr);
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        held_pc    = exp_addr;
        held_instr = word;
        exp_fetches++;
        check("valid", 32'(instr_valid), 32'd1);
        check("req_drop", 32'(imem_req), 32'd0);
        check("instr", instr, word);
        check("opcode", 32'(opcode), word >> 26);
        check("pc", pc, held_pc);
        check("pc_plus4", pc_plus4, held_pc + 32'd4);
    endtask

    // Hold in VALID for nstall cycles (redirect inputs and stray acks must be ignored), then consume.
    task automatic consume(input int nstall, input bit j, input bit b, input bit j_stall);
        for (int s = 0; s < nstall; s++) begin
            stall        = 1'b1;
            jump         = j_stall ? 1'b1 : 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            imem_ack     = 1'($urandom_range(0, 1));
            imem_rdata   = $urandom;
            tick();
            exp_stalls++;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_instr", instr, held_instr);
            check("stall_pc", pc, held_pc);
        end
        stall        = 1'b0;
        jump         = j;
        branch_taken = b;
        imem_ack     = 1'b0;
        tick();
        exp_addr = model_next(held_pc, held_instr, j, b);
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("consume_valid", 32'(instr_valid), 32'd0);
        check("consume_req", 32'(imem_req), 32'd1);
        check("next_addr", imem_addr, exp_addr);
    endtask

    initial begin
        reset_n      = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        stall        = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        exp_addr     = 32'h0000_0040;
        held_pc      = '0;
        held_instr   = '0;
        exp_fetches  = 0;
        exp_stalls   = 0;

        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'd4);
        check("rst_instr", instr, 32'd0);

        reset_n = 1'b1;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_0040);

        // Directed sequence
        do_fetch(32'h2008_0005, 0);            // addi at 0x40
        consume(0, 1'b0, 1'b0, 1'b0);          // -> 0x44
        do_fetch(32'h0800_0040, 3);            // j 0x100, delayed ack
        consume(5, 1'b1, 1'b0, 1'b1);          // stalled with jump held -> 0x100
        check("jump_target", imem_addr, 32'h0000_0100);
        do_fetch(32'h1000_FFFE, 0);            // branch -2 words at 0x100
        consume(0, 1'b0, 1'b1, 1'b0);
        check("branch_taken", imem_addr, 32'h0000_00FC);
        do_fetch(32'h0000_0000, 1);            // nop at 0xFC -> 0x100
        consume(0, 1'b0, 1'b0, 1'b0);
        do_fetch(32'h1000_FFFE, 0);
        consume(0, 1'b0, 1'b0, 1'b0);
        check("branch_not_taken", imem_addr, 32'h0000_0104);
        do_fetch(32'h0800_0040, 0);            // back to 0x100
        consume(0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h1000_FFFE, 0);
        consume(0, 1'b1, 1'b1, 1'b0);          // jump wins over branch
        check("jump_over_branch", imem_addr, 32'h0003_FFF8);
        do_fetch(32'h0800_0010, 0);            // j 0x40
        consume(0, 1'b1, 1'b0, 1'b0);
        do_fetch(32'h1000_FFEE, 0);            // branch at 0x40 wraps to 0xFFFF_FFFC
        consume(1, 1'b0, 1'b1, 1'b0);
        check("wrap_branch", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000, 0);
        check("wrap_pc_plus4", pc_plus4, 32'd0);
        consume(0, 1'b0, 1'b0, 1'b0);
        check("wrap_next", imem_addr, 32'd0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            do_fetch($urandom, $urandom_range(0, 3));
            consume($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0), 1'b0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'(exp_fetches));
        check("stall_count", stall_count, 32'(exp_stalls));
`endif

        // Reset during FETCH with an ack pending
        imem_ack = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        reset_n    = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_pc", pc, 32'd0);
        check("midrst_pc_plus4", pc_plus4, 32'd4);
        check("midrst_instr", instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_fetch_count", fetch_count, 32'd0);
        check("midrst_stall_count", stall_count, 32'd0);
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0000_0040);
        check("restart_instr", instr, 32'd0);
        check("restart_valid", 32'(instr_valid), 32'd0);
        imem_ack    = 1'b0;
        exp_addr    = 32'h0000_0040;
        held_pc     = '0;
        held_instr  = '0;
        exp_fetches = 0;
        exp_stalls  = 0;
        do_fetch(32'h2008_0005, 2);
        consume(2, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("post_fetch_count", fetch_count, 32'(exp_fetches));
        check("post_stall_count", stall_count, 32'(exp_stalls));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the MIPS core. It keeps the program counter and issues word requests to instruction memory over a req/ack handshake. It holds each returned instruction stable for the main decoder, with the opcode field split out, until downstream accepts it. When the instruction is accepted, it computes the next PC from the decoder's `jump` output and the resolved branch condition.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address. Bits [1:0] are forced to 0 internally.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word-aligned fetch address. Valid while `imem_req`=1.
- `imem_ack`  in  1  memory completes the request. `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream is not ready. The held instruction must not be consumed.
- `jump`  in  1  held instruction is a J-type jump (from the decoder).
- `branch_taken`  in  1  held instruction is a branch and its condition is true (Branch & zero).
- `instr`  out  32  held instruction.
- `opcode`  out  6  `instr[31:26]`, drives the decoder's `Opcode` input.
- `pc`  out  32  address of the held instruction.
- `pc_plus4`  out  32  `pc + 4`.
- `instr_valid`  out  1  `instr`, `opcode`, `pc` and `pc_plus4` are valid.

## Operation
- Registers: `fetch_pc`, `pc`, `instr`, state.
- FSM states: IDLE, FETCH, VALID.
- Reset values:
  - state = IDLE, `fetch_pc` = `RESET_PC`, `pc` = 0, `instr` = 0.
  - `imem_req` = 0, `instr_valid` = 0, `opcode` = 0, `pc_plus4` = 4.
- IDLE:
  - Outputs idle.
  - Go to FETCH unconditionally on the first clock edge after reset is released.
- FETCH:
  - `imem_req` = 1, `imem_addr` = `fetch_pc`, held stable until ack.
  - On `imem_ack`: `instr` <= `imem_rdata`, `pc` <= `fetch_pc`, go to VALID.
  - With no ack, stay in FETCH indefinitely.
- VALID:
  - `instr_valid` = 1, `imem_req` = 0.
  - `stall` = 1: all registers hold; `jump` and `branch_taken` are ignored.
  - `stall` = 0: instruction is consumed. Load `fetch_pc` with next PC, then go to FETCH.
- Next-PC priority:
  - `jump`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `branch_taken`: `pc_plus4` + (sign-extended `instr[15:0]` << 2).
  - else: `pc_plus4`.
- `jump` and `branch_taken` both high: jump wins.
- `jump`, `branch_taken` and `stall` are sampled only in VALID. They are don't-care elsewhere.
- Arithmetic is 32-bit modulo 2^32:
  - `pc` = 32'hFFFF_FFFC gives `pc_plus4` = 0.
  - Branch targets wrap the same way.
- `imem_ack` outside FETCH is ignored.

## Timing
- `imem_req` rises the cycle after reset release, plus one cycle for IDLE.
- With a zero-wait memory (`imem_ack` in the first FETCH cycle), `instr_valid` rises on the next edge.
- Fetch-to-valid latency is 1 cycle after the ack cycle.
- Peak throughput is one instruction per 2 cycles: FETCH, VALID, FETCH, ...
- `imem_req` falls on the edge after the ack and never stays high into VALID.
- `instr_valid` falls on the edge after VALID with `stall` = 0.
- Reset asserted mid-operation, including mid-request:
  - All outputs return to reset values immediately, asynchronously.
  - An outstanding memory ack after reset release is ignored until the fresh FETCH.
- The next PC is a registered result. `imem_addr` comes from a register, with no combinational path from `jump`/`branch_taken` to `imem_addr`.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds:
  - `fetch_count` out 32: increments once per `imem_ack` accepted in FETCH.
  - `stall_count` out 32: increments each cycle in VALID with `stall` = 1.
- Both counters reset to 0, wrap at 2^32, and add no latency.
- Undefined: both ports and all counter logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, `RESET_PC` = 32'h0000_0040, zero-wait memory returning 32'h2008_0005 (addi):
  - `imem_addr` = 0x40.
  - `instr_valid` is high 1 cycle after the ack, with `opcode` = 6'b001000, `pc` = 0x40, `pc_plus4` = 0x44.
- Memory ack delayed 3 cycles:
  - `imem_req` and `imem_addr` stay stable for 4 cycles.
  - `instr` is captured only on the ack cycle.
- `stall` high 5 cycles in VALID with `jump` = 1 throughout:
  - Outputs hold and no fetch is issued.
  - When `stall` drops, the next `imem_addr` is the jump target, e.g. `pc` = 0x1000_0000, `instr` = 32'h0800_0010 gives 0x1000_0040.
- Branch at `pc` = 0x100 with `instr[15:0]` = 16'hFFFE:
  - `branch_taken` = 1 gives next `imem_addr` = 0xFC.
  - `branch_taken` = 0 gives 0x104.
  - `jump` and `branch_taken` both 1 selects the jump target.
- Wrap: `pc` = 32'hFFFF_FFFC, no jump or branch, gives next `imem_addr` = 0 and `pc_plus4` = 0.
- `reset_n` pulsed low during FETCH with ack pending:
  - `imem_req` drops immediately.
  - After release, fetch restarts at `RESET_PC`.
  - With `FETCH_PERF_CNT_EN` defined, `fetch_count` and `stall_count` read 0.
